// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_if
// Description : Bundle between the ID-stage datapath and the pipelined
//               control unit. Carries the decoded ID fields and flush
//               into the control unit. Carries the staged controls,
//               the stall signal and the forwarding selects back out.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_if #(
  parameter int OPC_W   = 7,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 4
);
  // ID-stage instruction fields
  logic               id_valid;
  logic [2:0]         id_itype;
  logic [OPC_W-1:0]   id_opcode;
  logic [2:0]         id_funct3;
  logic [6:0]         id_funct7;
  logic [RA_W-1:0]    id_rs1;
  logic [RA_W-1:0]    id_rs2;
  logic [RA_W-1:0]    id_rd;
  logic               flush;

  // hazard and forwarding controls
  logic               stall;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;

  // EX-stage controls
  logic               ex_valid;
  logic               ex_alu_src;
  logic               ex_branch;
  logic               ex_jump;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [RA_W-1:0]    ex_rs1;
  logic [RA_W-1:0]    ex_rs2;

  // MEM-stage controls
  logic               mem_valid;
  logic               mem_read;
  logic               mem_write;

  // WB-stage controls
  logic               wb_valid;
  logic               wb_reg_write;
  logic               wb_mem_to_reg;
  logic [RA_W-1:0]    wb_rd;

  // datapath side: drives the ID fields and consumes the controls
  modport master (
    output id_valid, id_itype, id_opcode, id_funct3, id_funct7,
           id_rs1, id_rs2, id_rd, flush,
    input  stall, fwd_a, fwd_b,
           ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_rs1, ex_rs2,
           mem_valid, mem_read, mem_write,
           wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd
  );

  // control-unit side
  modport slave (
    input  id_valid, id_itype, id_opcode, id_funct3, id_funct7,
           id_rs1, id_rs2, id_rd, flush,
    output stall, fwd_a, fwd_b,
           ex_valid, ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_rs1, ex_rs2,
           mem_valid, mem_read, mem_write,
           wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Pipelined control unit for a 5-stage RV32I core. It decodes
//               the control signals in ID and registers them through EX, MEM
//               and WB. It also generates the load-use stall, the
//               flush/stall bubble and the EX-stage forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
  parameter int OPC_W   = 7,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 4   // must be >= 4; upper bits are always zero
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_pipe_if.slave bus
);

  // instruction formats
  localparam logic [2:0] c_IT_R = 3'd0;
  localparam logic [2:0] c_IT_I = 3'd1;
  localparam logic [2:0] c_IT_S = 3'd2;
  localparam logic [2:0] c_IT_B = 3'd3;
  localparam logic [2:0] c_IT_U = 3'd4;
  localparam logic [2:0] c_IT_J = 3'd5;

  // opcodes that refine the format decode
  localparam logic [OPC_W-1:0] c_OP_LOAD  = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] c_OP_OPIMM = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] c_OP_JALR  = OPC_W'(7'b1100111);
  localparam logic [OPC_W-1:0] c_OP_LUI   = OPC_W'(7'b0110111);

  // ALU operations
  localparam logic [3:0] c_ALU_ADD    = 4'd0;
  localparam logic [3:0] c_ALU_SUB    = 4'd1;
  localparam logic [3:0] c_ALU_AND    = 4'd2;
  localparam logic [3:0] c_ALU_OR     = 4'd3;
  localparam logic [3:0] c_ALU_XOR    = 4'd4;
  localparam logic [3:0] c_ALU_SLL    = 4'd5;
  localparam logic [3:0] c_ALU_SRL    = 4'd6;
  localparam logic [3:0] c_ALU_SRA    = 4'd7;
  localparam logic [3:0] c_ALU_SLT    = 4'd8;
  localparam logic [3:0] c_ALU_SLTU   = 4'd9;
  localparam logic [3:0] c_ALU_PASS_B = 4'd10;

  // funct3 -> ALU op. The sub_ok input is cleared for OP-IMM, where funct7
  // bits are immediate bits except for shifts.
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3,
                                           input logic       f7b5,
                                           input logic       sub_ok);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (sub_ok && f7b5) ? c_ALU_SUB : c_ALU_ADD;
      3'b001:  op = c_ALU_SLL;
      3'b010:  op = c_ALU_SLT;
      3'b011:  op = c_ALU_SLTU;
      3'b100:  op = c_ALU_XOR;
      3'b101:  op = f7b5 ? c_ALU_SRA : c_ALU_SRL;
      3'b110:  op = c_ALU_OR;
      default: op = c_ALU_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------- decode
  logic w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j;
  logic w_reg_write, w_mem_read, w_mem_write, w_alu_src;
  logic w_branch, w_jump, w_uses_rs1, w_uses_rs2;
  logic [3:0] w_alu_op4;
  logic w_unused_f7;

  assign w_is_r = (bus.id_itype == c_IT_R);
  assign w_is_i = (bus.id_itype == c_IT_I);
  assign w_is_s = (bus.id_itype == c_IT_S);
  assign w_is_b = (bus.id_itype == c_IT_B);
  assign w_is_u = (bus.id_itype == c_IT_U);
  assign w_is_j = (bus.id_itype == c_IT_J);

  // formats 6 and 7 match none of the above, so every control stays 0
  assign w_reg_write = (w_is_r || w_is_i || w_is_u || w_is_j) && (bus.id_rd != '0);
  assign w_mem_read  = w_is_i && (bus.id_opcode == c_OP_LOAD);
  assign w_mem_write = w_is_s;
  assign w_alu_src   = w_is_i || w_is_s || w_is_u || w_is_j;
  assign w_branch    = w_is_b;
  assign w_jump      = w_is_j || (w_is_i && (bus.id_opcode == c_OP_JALR));
  assign w_uses_rs1  = w_is_r || w_is_i || w_is_s || w_is_b;
  assign w_uses_rs2  = w_is_r || w_is_s || w_is_b;

  // only funct7[5] matters to the decode
  assign w_unused_f7 = ^{bus.id_funct7[6], bus.id_funct7[4:0]};

  // ALU op selection by format, refined by opcode/funct fields
  always_comb begin
    w_alu_op4 = c_ALU_ADD;
    case (bus.id_itype)
      c_IT_R: w_alu_op4 = f3_to_alu(bus.id_funct3, bus.id_funct7[5], 1'b1);
      c_IT_I: if (bus.id_opcode == c_OP_OPIMM)
                w_alu_op4 = f3_to_alu(bus.id_funct3, bus.id_funct7[5], 1'b0);
      c_IT_B: w_alu_op4 = c_ALU_SUB;
      c_IT_U: if (bus.id_opcode == c_OP_LUI)
                w_alu_op4 = c_ALU_PASS_B;
      default: w_alu_op4 = c_ALU_ADD;
    endcase
  end

  // ---------------------------------------------------------- stage state
  logic               r_ex_valid, r_ex_alu_src, r_ex_branch, r_ex_jump;
  logic               r_ex_reg_write, r_ex_mem_read, r_ex_mem_write, r_ex_mem_to_reg;
  logic [ALUOP_W-1:0] r_ex_alu_op;
  logic [RA_W-1:0]    r_ex_rs1, r_ex_rs2, r_ex_rd;

  logic               r_mem_valid, r_mem_read, r_mem_write, r_mem_reg_write, r_mem_mem_to_reg;
  logic [RA_W-1:0]    r_mem_rd;

  logic               r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg;
  logic [RA_W-1:0]    r_wb_rd;

  // ------------------------------------------------------ load-use hazard
  logic w_stall, w_ex_load;

  // a load in EX whose rd feeds a source the ID instruction actually reads
  assign w_stall = bus.id_valid && !bus.flush &&
                   r_ex_valid && r_ex_mem_read && (r_ex_rd != '0) &&
                   (((r_ex_rd == bus.id_rs1) && w_uses_rs1) ||
                    ((r_ex_rd == bus.id_rs2) && w_uses_rs2));

  // flush and stall both turn the EX load into a bubble
  assign w_ex_load = bus.id_valid && !bus.flush && !w_stall;

  // ID -> EX register: decoded bundle, or an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_jump       <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_alu_op     <= '0;
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_ex_rd         <= '0;
    end else if (w_ex_load) begin
      r_ex_valid      <= 1'b1;
      r_ex_alu_src    <= w_alu_src;
      r_ex_branch     <= w_branch;
      r_ex_jump       <= w_jump;
      r_ex_reg_write  <= w_reg_write;
      r_ex_mem_read   <= w_mem_read;
      r_ex_mem_write  <= w_mem_write;
      r_ex_mem_to_reg <= w_mem_read;
      r_ex_alu_op     <= ALUOP_W'(w_alu_op4);
      // unused source fields are zeroed so they can never match a forward
      r_ex_rs1        <= w_uses_rs1 ? bus.id_rs1 : '0;
      r_ex_rs2        <= w_uses_rs2 ? bus.id_rs2 : '0;
      r_ex_rd         <= bus.id_rd;
    end else begin
      r_ex_valid      <= 1'b0;
      r_ex_alu_src    <= 1'b0;
      r_ex_branch     <= 1'b0;
      r_ex_jump       <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_ex_mem_write  <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_alu_op     <= '0;
      r_ex_rs1        <= '0;
      r_ex_rs2        <= '0;
      r_ex_rd         <= '0;
    end
  end

  // EX -> MEM register: always advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_rd         <= '0;
    end else begin
      r_mem_valid      <= r_ex_valid;
      r_mem_read       <= r_ex_mem_read;
      r_mem_write      <= r_ex_mem_write;
      r_mem_reg_write  <= r_ex_reg_write;
      r_mem_mem_to_reg <= r_ex_mem_to_reg;
      r_mem_rd         <= r_ex_rd;
    end
  end

  // MEM -> WB register: always advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_rd         <= '0;
    end else begin
      r_wb_valid      <= r_mem_valid;
      r_wb_reg_write  <= r_mem_reg_write;
      r_wb_mem_to_reg <= r_mem_mem_to_reg;
      r_wb_rd         <= r_mem_rd;
    end
  end

  // ----------------------------------------------------------- forwarding
  logic       w_mem_fwd_ok, w_wb_fwd_ok;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_mem_fwd_ok = r_mem_valid && r_mem_reg_write && (r_mem_rd != '0);
  assign w_wb_fwd_ok  = r_wb_valid  && r_wb_reg_write  && (r_wb_rd  != '0);

  // EX operand sources; the younger MEM result wins over WB
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs1))     w_fwd_a = 2'b10;
    else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs1))  w_fwd_a = 2'b01;
    if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs2))     w_fwd_b = 2'b10;
    else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs2))  w_fwd_b = 2'b01;
  end

  // -------------------------------------------------------------- outputs
  assign bus.stall         = w_stall;
  assign bus.fwd_a         = w_fwd_a;
  assign bus.fwd_b         = w_fwd_b;

  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_alu_src    = r_ex_alu_src;
  assign bus.ex_branch     = r_ex_branch;
  assign bus.ex_jump       = r_ex_jump;
  assign bus.ex_alu_op     = r_ex_alu_op;
  assign bus.ex_rs1        = r_ex_rs1;
  assign bus.ex_rs2        = r_ex_rs2;

  assign bus.mem_valid     = r_mem_valid;
  assign bus.mem_read      = r_mem_read;
  assign bus.mem_write     = r_mem_write;

  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_reg_write  = r_wb_reg_write;
  assign bus.wb_mem_to_reg = r_wb_mem_to_reg;
  assign bus.wb_rd         = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe
// Description : Self-checking bench for ctrl_pipe. A decode table is walked
//               one instruction at a time through EX, MEM and WB. Directed
//               sequences cover load-use stall, forwarding priority,
//               flush vs stall, and asynchronous reset mid-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_OPIMM = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_BR    = 7'b1100011;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_F7_ALT   = 7'b0100000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ctrl_pipe_if #(.OPC_W(7), .RA_W(5), .ALUOP_W(4)) bus ();

  ctrl_pipe #(.OPC_W(7), .RA_W(5), .ALUOP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       valid;
    logic [2:0] itype;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       e_valid;
    logic [3:0] e_alu;
    logic       e_src;
    logic       e_br;
    logic       e_j;
    logic       e_mr;
    logic       e_mw;
    logic       e_rw;
    logic       e_m2r;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [2:0] it, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                              input logic ev, input logic [3:0] alu, input logic src,
                              input logic br, input logic j, input logic mr, input logic mw,
                              input logic rw, input logic m2r);
    vec_t t;
    t.valid = v;  t.itype = it; t.op = op; t.f3 = f3; t.f7 = f7; t.rd = rd;
    t.e_valid = ev; t.e_alu = alu; t.e_src = src; t.e_br = br; t.e_j = j;
    t.e_mr = mr; t.e_mw = mw; t.e_rw = rw; t.e_m2r = m2r;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] it, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic fl);
    bus.id_valid  = v;
    bus.id_itype  = it;
    bus.id_opcode = op;
    bus.id_funct3 = f3;
    bus.id_funct7 = f7;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
    bus.id_rd     = rd;
    bus.flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ex_valid"},     32'(bus.ex_valid),     32'd0);
    chk({tag, ".ex_alu_op"},    32'(bus.ex_alu_op),    32'd0);
    chk({tag, ".mem_valid"},    32'(bus.mem_valid),    32'd0);
    chk({tag, ".mem_read"},     32'(bus.mem_read),     32'd0);
    chk({tag, ".wb_valid"},     32'(bus.wb_valid),     32'd0);
    chk({tag, ".wb_reg_write"}, 32'(bus.wb_reg_write), 32'd0);
    chk({tag, ".wb_rd"},        32'(bus.wb_rd),        32'd0);
    chk({tag, ".stall"},        32'(bus.stall),        32'd0);
    chk({tag, ".fwd_a"},        32'(bus.fwd_a),        32'd0);
    chk({tag, ".fwd_b"},        32'(bus.fwd_b),        32'd0);
  endtask

  initial begin
    vec_t  v;
    string s;
    n_cmp = 0;
    n_err = 0;

    //           v  it    op          f3    f7        rd     ev alu   src br j  mr mw rw m2r
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd0, 7'd0,     5'd3, 1, 4'd0, 0, 0, 0, 0, 0, 1, 0)); // add
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd0, c_F7_ALT, 5'd3, 1, 4'd1, 0, 0, 0, 0, 0, 1, 0)); // sub
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd1, 7'd0,     5'd3, 1, 4'd5, 0, 0, 0, 0, 0, 1, 0)); // sll
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd2, 7'd0,     5'd3, 1, 4'd8, 0, 0, 0, 0, 0, 1, 0)); // slt
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd3, 7'd0,     5'd3, 1, 4'd9, 0, 0, 0, 0, 0, 1, 0)); // sltu
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd4, 7'd0,     5'd3, 1, 4'd4, 0, 0, 0, 0, 0, 1, 0)); // xor
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd5, 7'd0,     5'd3, 1, 4'd6, 0, 0, 0, 0, 0, 1, 0)); // srl
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd5, c_F7_ALT, 5'd3, 1, 4'd7, 0, 0, 0, 0, 0, 1, 0)); // sra
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd6, 7'd0,     5'd3, 1, 4'd3, 0, 0, 0, 0, 0, 1, 0)); // or
    vecs.push_back(mk(1, 3'd0, c_OP_R,     3'd7, 7'd0,     5'd3, 1, 4'd2, 0, 0, 0, 0, 0, 1, 0)); // and
    vecs.push_back(mk(1, 3'd1, c_OP_OPIMM, 3'd0, c_F7_ALT, 5'd4, 1, 4'd0, 1, 0, 0, 0, 0, 1, 0)); // addi, never sub
    vecs.push_back(mk(1, 3'd1, c_OP_OPIMM, 3'd5, c_F7_ALT, 5'd4, 1, 4'd7, 1, 0, 0, 0, 0, 1, 0)); // srai
    vecs.push_back(mk(1, 3'd1, c_OP_OPIMM, 3'd2, 7'd0,     5'd4, 1, 4'd8, 1, 0, 0, 0, 0, 1, 0)); // slti
    vecs.push_back(mk(1, 3'd1, c_OP_OPIMM, 3'd7, 7'd0,     5'd4, 1, 4'd2, 1, 0, 0, 0, 0, 1, 0)); // andi
    vecs.push_back(mk(1, 3'd1, c_OP_LOAD,  3'd2, 7'd0,     5'd6, 1, 4'd0, 1, 0, 0, 1, 0, 1, 1)); // lw
    vecs.push_back(mk(1, 3'd2, c_OP_STORE, 3'd2, 7'd0,     5'd1, 1, 4'd0, 1, 0, 0, 0, 1, 0, 0)); // sw
    vecs.push_back(mk(1, 3'd3, c_OP_BR,    3'd0, 7'd0,     5'd2, 1, 4'd1, 0, 1, 0, 0, 0, 0, 0)); // beq
    vecs.push_back(mk(1, 3'd4, c_OP_LUI,   3'd0, 7'd0,     5'd5, 1, 4'd10,1, 0, 0, 0, 0, 1, 0)); // lui
    vecs.push_back(mk(1, 3'd4, c_OP_AUIPC, 3'd0, 7'd0,     5'd5, 1, 4'd0, 1, 0, 0, 0, 0, 1, 0)); // auipc
    vecs.push_back(mk(1, 3'd5, c_OP_JAL,   3'd0, 7'd0,     5'd1, 1, 4'd0, 1, 0, 1, 0, 0, 1, 0)); // jal
    vecs.push_back(mk(1, 3'd1, c_OP_JALR,  3'd0, 7'd0,     5'd1, 1, 4'd0, 1, 0, 1, 0, 0, 1, 0)); // jalr
    vecs.push_back(mk(1, 3'd1, c_OP_OPIMM, 3'd0, 7'd0,     5'd0, 1, 4'd0, 1, 0, 0, 0, 0, 0, 0)); // addi x0
    vecs.push_back(mk(1, 3'd6, c_OP_R,     3'd0, c_F7_ALT, 5'd3, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0)); // illegal 6
    vecs.push_back(mk(1, 3'd7, c_OP_LOAD,  3'd0, 7'd0,     5'd3, 1, 4'd0, 0, 0, 0, 0, 0, 0, 0)); // illegal 7
    vecs.push_back(mk(0, 3'd0, c_OP_R,     3'd0, 7'd0,     5'd3, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0)); // no instr

    // ---- reset state
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #2 rst_n = 1'b1;

    // ---- decode table, one instruction at a time through all stages
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.valid, v.itype, v.op, v.f3, v.f7, 5'd0, 5'd0, v.rd, 1'b0);
      tick();
      s = $sformatf("v%0d", i);
      chk({s, ".ex_valid"},   32'(bus.ex_valid),   32'(v.e_valid));
      chk({s, ".ex_alu_op"},  32'(bus.ex_alu_op),  32'(v.e_alu));
      chk({s, ".ex_alu_src"}, 32'(bus.ex_alu_src), 32'(v.e_src));
      chk({s, ".ex_branch"},  32'(bus.ex_branch),  32'(v.e_br));
      chk({s, ".ex_jump"},    32'(bus.ex_jump),    32'(v.e_j));
      idle();
      tick();
      chk({s, ".mem_valid"},  32'(bus.mem_valid),  32'(v.e_valid));
      chk({s, ".mem_read"},   32'(bus.mem_read),   32'(v.e_mr));
      chk({s, ".mem_write"},  32'(bus.mem_write),  32'(v.e_mw));
      tick();
      chk({s, ".wb_valid"},      32'(bus.wb_valid),      32'(v.e_valid));
      chk({s, ".wb_reg_write"},  32'(bus.wb_reg_write),  32'(v.e_rw));
      chk({s, ".wb_mem_to_reg"}, 32'(bus.wb_mem_to_reg), 32'(v.e_m2r));
      if (v.e_rw) chk({s, ".wb_rd"}, 32'(bus.wb_rd), 32'(v.rd));
    end

    // ---- load-use: lw x5 ; add x6,x5,x7
    drive(1, 3'd1, c_OP_LOAD, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5, 0);
    tick();
    drive(1, 3'd0, c_OP_R, 3'd0, 7'd0, 5'd5, 5'd7, 5'd6, 0);
    #1;
    chk("lu.stall_on", 32'(bus.stall), 32'd1);
    tick();
    chk("lu.bubble_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu.load_in_mem",     32'(bus.mem_read), 32'd1);
    chk("lu.stall_off",       32'(bus.stall),    32'd0);
    tick();
    chk("lu.add_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu.add_ex_rs1",   32'(bus.ex_rs1),   32'd5);
    chk("lu.fwd_a",        32'(bus.fwd_a),    32'd1);
    chk("lu.fwd_b",        32'(bus.fwd_b),    32'd0);
    idle();

    // ---- load-use via rs2 only
    drive(1, 3'd1, c_OP_LOAD, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5, 0);
    tick();
    drive(1, 3'd0, c_OP_R, 3'd0, 7'd0, 5'd7, 5'd5, 5'd6, 0);
    #1;
    chk("lu_rs2.stall", 32'(bus.stall), 32'd1);
    // an I-type does not read its rs2 field
    drive(1, 3'd1, c_OP_OPIMM, 3'd0, 7'd0, 5'd1, 5'd5, 5'd6, 0);
    #1;
    chk("lu_itype_rs2.stall", 32'(bus.stall), 32'd0);
    idle();
    tick();

    // ---- load to x0 never stalls
    drive(1, 3'd1, c_OP_LOAD, 3'd2, 7'd0, 5'd1, 5'd0, 5'd0, 0);
    tick();
    drive(1, 3'd0, c_OP_R, 3'd0, 7'd0, 5'd0, 5'd0, 5'd6, 0);
    #1;
    chk("lu_x0.stall", 32'(bus.stall), 32'd0);
    idle();
    tick();

    // ---- forward priority: add x3 ; sub x3 ; or x4,x3,x3
    drive(1, 3'd0, c_OP_R, 3'd0, 7'd0,     5'd1, 5'd2, 5'd3, 0); tick();
    drive(1, 3'd0, c_OP_R, 3'd0, c_F7_ALT, 5'd1, 5'd2, 5'd3, 0); tick();
    drive(1, 3'd0, c_OP_R, 3'd6, 7'd0,     5'd3, 5'd3, 5'd4, 0); tick();
    chk("fwd_pri.fwd_a", 32'(bus.fwd_a), 32'd2);
    chk("fwd_pri.fwd_b", 32'(bus.fwd_b), 32'd2);

    // ---- same shape with x0 as destination and source
    drive(1, 3'd0, c_OP_R, 3'd0, 7'd0,     5'd1, 5'd2, 5'd0, 0); tick();
    drive(1, 3'd0, c_OP_R, 3'd0, c_F7_ALT, 5'd1, 5'd2, 5'd0, 0); tick();
    drive(1, 3'd0, c_OP_R, 3'd6, 7'd0,     5'd0, 5'd0, 5'd4, 0); tick();
    chk("fwd_x0.fwd_a", 32'(bus.fwd_a), 32'd0);
    chk("fwd_x0.fwd_b", 32'(bus.fwd_b), 32'd0);

    // ---- WB-only forward: add x3 ; bubble ; or x4,x3,x0
    drive(1, 3'd0, c_OP_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 0); tick();
    idle(); tick();
    drive(1, 3'd0, c_OP_R, 3'd6, 7'd0, 5'd3, 5'd0, 5'd4, 0); tick();
    chk("fwd_wb.fwd_a", 32'(bus.fwd_a), 32'd1);
    chk("fwd_wb.fwd_b", 32'(bus.fwd_b), 32'd0);
    idle();
    tick();

    // ---- flush in the same cycle as a load-use hazard
    drive(1, 3'd1, c_OP_LOAD, 3'd2, 7'd0, 5'd1, 5'd0, 5'd5, 0);
    tick();
    drive(1, 3'd0, c_OP_R, 3'd0, 7'd0, 5'd5, 5'd7, 5'd6, 1);
    #1;
    chk("flush.stall", 32'(bus.stall), 32'd0);
    tick();
    chk("flush.ex_valid",  32'(bus.ex_valid),  32'd0);
    chk("flush.mem_valid", 32'(bus.mem_valid), 32'd1);
    chk("flush.mem_read",  32'(bus.mem_read),  32'd1);
    idle();
    tick();

    // ---- asynchronous reset with every stage holding a valid instruction
    drive(1, 3'd1, c_OP_OPIMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 0); tick();
    drive(1, 3'd1, c_OP_OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd2, 0); tick();
    drive(1, 3'd1, c_OP_OPIMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd3, 0); tick();
    chk("pre_rst.wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("pre_rst.fwd_a",    32'(bus.fwd_a),    32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2 rst_n = 1'b1;
    drive(1, 3'd1, c_OP_OPIMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 0);
    tick();
    chk("post_rst.ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("post_rst.wb_valid_early", 32'(bus.wb_valid), 32'd0);
    idle();
    tick();
    tick();
    chk("post_rst.wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("post_rst.wb_rd",    32'(bus.wb_rd),    32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
